img_disp_ctrl: RTL and testbench
================================

IMG_DISP_CTRL -- requirements
Module: img_disp_ctrl

Interface
REQ-001 SHALL have parameter IMG_W_LOG2, default 3, meaning log2 of image width (columns), legal range 2..6.
REQ-002 SHALL have parameter IMG_H_LOG2, default 3, meaning log2 of image height (rows), legal range 2..6.
REQ-003 SHALL have parameter PIX_W, default 8, meaning pixel width in bits, legal range 4..16; derived AW = IMG_W_LOG2+IMG_H_LOG2, N = 2^AW.
REQ-004 SHALL have ports: clk  in  1  sole clock, rising edge; reset  in  1  asynchronous, active-low.
REQ-005 SHALL have ports: cmd  in  4  command code; cmd_valid  in  1  command strobe.
REQ-006 SHALL have ports: IROM_Q  in  PIX_W  ROM data; IROM_rd  out  1  ROM read enable; IROM_A  out  AW  ROM address.
REQ-007 SHALL have ports: IRAM_valid  out  1  RAM write strobe; IRAM_D  out  PIX_W  RAM data; IRAM_A  out  AW  RAM address.
REQ-008 SHALL have ports: busy  out  1  commands refused; done  out  1  write-out complete pulse.

Function
REQ-009 SHALL hold an N-entry PIX_W image buffer, address = row*2^IMG_W_LOG2 + col.
REQ-010 SHALL use FSM states LOAD, IDLE, EXEC, WRITE; LOAD entered on reset release.
REQ-011 LOAD: IROM_rd=1, IROM_A steps 0..N-1 one per cycle; IROM_Q valid one cycle after its address and SHALL be captured then; after pixel N-1 captured, IROM_rd=0, busy=0 next cycle, go IDLE.
REQ-012 Command accepted only when cmd_valid=1 and busy=0; cmd_valid while busy=1 SHALL be ignored, not queued.
REQ-013 Accepted non-Write command: busy=1 for exactly one cycle (EXEC), buffer/point update effective at that edge, return IDLE.
REQ-014 Operation point (X,Y) = bottom-right pixel of 2x2 window TL(X-1,Y-1) TR(X,Y-1) BL(X-1,Y) BR(X,Y); X in 1..W-1, Y in 1..H-1; reset/reload value (W/2, H/2).
REQ-015 Codes: 0 Write; 1 Up (Y-1); 2 Down (Y+1); 3 Left (X-1); 4 Right (X+1); shifts SHALL saturate at range bounds, no wrap.
REQ-016 Codes 5 Max, 6 Min, 7 Average: all four window pixels <= result; Average sum SHALL be AW-independent PIX_W+2 bits wide, result = sum>>2 (truncate unless REQ-026).
REQ-017 Code 8 CCW: TL<=TR, TR<=BR, BR<=BL, BL<=TL; code 9 CW: TL<=BL, BL<=BR, BR<=TR, TR<=TL.
REQ-018 Code A Mirror-X: TL<->BL, TR<->BR; code B Mirror-Y: TL<->TR, BL<->BR.
REQ-019 Code C Reload: busy=1, re-enter LOAD, reset operation point; codes D-F: one-cycle EXEC no-op.
REQ-020 Write: busy=1; IRAM_A steps 0..N-1, IRAM_D = buffer[IRAM_A], IRAM_valid=1 each of N consecutive cycles.
REQ-021 Cycle after last write beat: IRAM_valid=0, done=1 for exactly one cycle, busy=0, state IDLE; further commands and Writes SHALL be legal.
REQ-022 done SHALL be 0 in every cycle except REQ-021 pulse.

Reset
REQ-023 reset=0 SHALL asynchronously force: state LOAD, busy=1, IROM_rd=0, IROM_A=0, IRAM_valid=0, IRAM_D=0, IRAM_A=0, done=0, point (W/2,H/2).
REQ-024 First cycle after reset deassert SHALL drive IROM_rd=1, IROM_A=0; reset mid-LOAD/WRITE SHALL abort and restart LOAD; buffer contents need not reset.

Configuration
REQ-025 Macro IMG_DISP_CTRL_ROUND_EN SHALL select Average rounding.
REQ-026 Defined: Average = (sum+2)>>2 (round half up); undefined: Average = sum>>2; all else identical.

Structure
REQ-027 Package img_disp_pkg SHALL hold the command-code enum, FSM state enum, and derived AW/window-offset helper constants.
REQ-028 Sub-module img_win_alu SHALL compute max, min, average of four PIX_W pixels combinationally; FSM, buffer, counters stay in img_disp_ctrl.

Verification
REQ-029 Default params, ROM[i]=i: after reset -> 64 IROM reads, busy falls, Write -> IRAM_D=i at IRAM_A=i, done pulses once.
REQ-030 Up x5 then Left x5 from (4,4) -> point (1,1); Max -> buffer[0,1,8,9]=9.
REQ-031 Window values TL=10 TR=20 BL=30 BR=41, Average -> 25 without macro, 25 with macro; TR=21 -> 25 / 26.
REQ-032 TL=1 TR=2 BL=3 BR=4: CW -> TL=3 TR=1 BL=4 BR=2; then CCW -> original; Mirror-X -> TL=3 BL=1.
REQ-033 cmd_valid held during WRITE and EXEC -> ignored, buffer unchanged; second Write after done -> identical 64-beat stream.
REQ-034 IMG_W_LOG2=4, IMG_H_LOG2=2, PIX_W=10: reset low at WRITE beat 20 -> outputs cleared immediately, full 64-pixel reload, point (8,2).

Source files
------------

// File: rtl/img_disp_pkg.sv
// Shared types and helper constants for the image display controller.
// Optional Average rounding is selected by IMG_DISP_CTRL_ROUND_EN (see img_win_alu).
package img_disp_pkg;

  typedef enum logic [3:0] {
    CMD_WRITE  = 4'h0,
    CMD_UP     = 4'h1,
    CMD_DOWN   = 4'h2,
    CMD_LEFT   = 4'h3,
    CMD_RIGHT  = 4'h4,
    CMD_MAX    = 4'h5,
    CMD_MIN    = 4'h6,
    CMD_AVG    = 4'h7,
    CMD_CCW    = 4'h8,
    CMD_CW     = 4'h9,
    CMD_MIRX   = 4'hA,
    CMD_MIRY   = 4'hB,
    CMD_RELOAD = 4'hC,
    CMD_NOP_D  = 4'hD,
    CMD_NOP_E  = 4'hE,
    CMD_NOP_F  = 4'hF
  } cmd_e;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    IDLE  = 2'd1,
    EXEC  = 2'd2,
    WRITE = 2'd3
  } state_e;

  // The operation point is the bottom-right pixel; the window reaches one column left, one row up.
  localparam int WIN_DX = 1;
  localparam int WIN_DY = 1;

  function automatic int calc_aw(input int w_log2, input int h_log2);
    return w_log2 + h_log2;
  endfunction

endpackage

// File: rtl/img_win_alu.sv
// Combinational max/min/average of a 2x2 pixel window.
// IMG_DISP_CTRL_ROUND_EN defined: average rounds half up; otherwise it truncates.
module img_win_alu #(
  parameter int PIX_W = 8
) (
  input  logic [PIX_W-1:0] tl,
  input  logic [PIX_W-1:0] tr,
  input  logic [PIX_W-1:0] bl,
  input  logic [PIX_W-1:0] br,
  output logic [PIX_W-1:0] pix_max,
  output logic [PIX_W-1:0] pix_min,
  output logic [PIX_W-1:0] pix_avg
);

  localparam int SUM_W = PIX_W + 2;

  function automatic logic [PIX_W-1:0] max2(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [PIX_W-1:0] min2(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  // Four pixels sum into PIX_W+2 bits; +2 before the shift cannot overflow that width.
  function automatic logic [PIX_W-1:0] avg_div4(input logic [SUM_W-1:0] sum);
    logic [SUM_W-1:0] adj;
`ifdef IMG_DISP_CTRL_ROUND_EN
    adj = sum + SUM_W'(2);
`else
    adj = sum;
`endif
    return adj[SUM_W-1:2];
  endfunction

  logic [SUM_W-1:0] win_sum;

  assign win_sum = SUM_W'(tl) + SUM_W'(tr) + SUM_W'(bl) + SUM_W'(br);
  assign pix_max = max2(max2(tl, tr), max2(bl, br));
  assign pix_min = min2(min2(tl, tr), min2(bl, br));
  assign pix_avg = avg_div4(win_sum);

endmodule

// File: rtl/img_disp_ctrl.sv
// Image display controller: loads an image from ROM, applies 2x2 window commands, writes it to RAM.
// Build option IMG_DISP_CTRL_ROUND_EN selects round-half-up for the Average command.
module img_disp_ctrl
  import img_disp_pkg::*;
#(
  parameter int IMG_W_LOG2 = 3,
  parameter int IMG_H_LOG2 = 3,
  parameter int PIX_W      = 8,
  localparam int AW        = calc_aw(IMG_W_LOG2, IMG_H_LOG2)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       cmd,
  input  logic             cmd_valid,
  input  logic [PIX_W-1:0] IROM_Q,
  output logic             IROM_rd,
  output logic [AW-1:0]    IROM_A,
  output logic             IRAM_valid,
  output logic [PIX_W-1:0] IRAM_D,
  output logic [AW-1:0]    IRAM_A,
  output logic             busy,
  output logic             done
);

  localparam int N = 1 << AW;
  localparam int W = 1 << IMG_W_LOG2;
  localparam int H = 1 << IMG_H_LOG2;
  localparam logic [IMG_W_LOG2-1:0] X_HOME = IMG_W_LOG2'(W / 2);
  localparam logic [IMG_H_LOG2-1:0] Y_HOME = IMG_H_LOG2'(H / 2);
  localparam logic [IMG_W_LOG2-1:0] X_MIN  = IMG_W_LOG2'(WIN_DX);
  localparam logic [IMG_H_LOG2-1:0] Y_MIN  = IMG_H_LOG2'(WIN_DY);
  localparam logic [IMG_W_LOG2-1:0] X_MAX  = IMG_W_LOG2'(W - 1);
  localparam logic [IMG_H_LOG2-1:0] Y_MAX  = IMG_H_LOG2'(H - 1);
  localparam logic [AW-1:0]         ADDR0  = '0;
  localparam logic [AW-1:0]         LAST   = AW'(N - 1);

  state_e state, state_nxt;
  cmd_e   cmd_c;
  logic   accept, ld_last, wr_last;
  logic   rd_done, vld_p1;
  logic [AW-1:0] addr_p1;

  logic [IMG_W_LOG2-1:0] pt_x, x_left;
  logic [IMG_H_LOG2-1:0] pt_y, y_top;
  logic [AW-1:0]         a_tl, a_tr, a_bl, a_br;

  logic [PIX_W-1:0] img_buf [N];
  logic [PIX_W-1:0] w_tl, w_tr, w_bl, w_br;
  logic [PIX_W-1:0] pix_max, pix_min, pix_avg;

  assign cmd_c   = cmd_e'(cmd);
  assign busy    = (state != IDLE);
  assign accept  = cmd_valid && (state == IDLE);
  assign ld_last = vld_p1 && (addr_p1 == LAST);
  assign wr_last = IRAM_valid && (IRAM_A == LAST);

  assign x_left = pt_x - IMG_W_LOG2'(WIN_DX);
  assign y_top  = pt_y - IMG_H_LOG2'(WIN_DY);
  assign a_tl   = {y_top, x_left};
  assign a_tr   = {y_top, pt_x};
  assign a_bl   = {pt_y, x_left};
  assign a_br   = {pt_y, pt_x};

  assign w_tl = img_buf[a_tl];
  assign w_tr = img_buf[a_tr];
  assign w_bl = img_buf[a_bl];
  assign w_br = img_buf[a_br];

  img_win_alu #(.PIX_W(PIX_W)) u_alu (
    .tl      (w_tl),
    .tr      (w_tr),
    .bl      (w_bl),
    .br      (w_br),
    .pix_max (pix_max),
    .pix_min (pix_min),
    .pix_avg (pix_avg)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= LOAD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:  if (ld_last) state_nxt = IDLE;
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_c == CMD_WRITE)       state_nxt = WRITE;
          else if (cmd_c == CMD_RELOAD) state_nxt = LOAD;
          else                          state_nxt = EXEC;
        end
      end
      EXEC:  state_nxt = IDLE;
      WRITE: if (wr_last) state_nxt = IDLE;
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      IROM_rd    <= 1'b0;
      IROM_A     <= '0;
      rd_done    <= 1'b0;
      vld_p1     <= 1'b0;
      addr_p1    <= '0;
      IRAM_valid <= 1'b0;
      IRAM_A     <= '0;
      IRAM_D     <= '0;
      done       <= 1'b0;
      pt_x       <= X_HOME;
      pt_y       <= Y_HOME;
    end else begin
      done <= 1'b0;
      // ROM read issue -> p1: data for addr_p1 is on IROM_Q while vld_p1 is high
      vld_p1  <= IROM_rd;
      addr_p1 <= IROM_A;
      if (state == LOAD && !rd_done) begin
        IROM_rd <= 1'b1;
        if (IROM_rd) begin
          if (IROM_A == LAST) begin
            IROM_rd <= 1'b0;
            rd_done <= 1'b1;
          end else begin
            IROM_A <= IROM_A + AW'(1);
          end
        end
      end
      if (accept) begin
        case (cmd_c)
          CMD_WRITE: begin
            IRAM_valid <= 1'b1;
            IRAM_A     <= ADDR0;
            IRAM_D     <= img_buf[ADDR0];
          end
          CMD_UP:    if (pt_y > Y_MIN) pt_y <= pt_y - IMG_H_LOG2'(1);
          CMD_DOWN:  if (pt_y < Y_MAX) pt_y <= pt_y + IMG_H_LOG2'(1);
          CMD_LEFT:  if (pt_x > X_MIN) pt_x <= pt_x - IMG_W_LOG2'(1);
          CMD_RIGHT: if (pt_x < X_MAX) pt_x <= pt_x + IMG_W_LOG2'(1);
          CMD_RELOAD: begin
            IROM_A  <= '0;
            rd_done <= 1'b0;
            pt_x    <= X_HOME;
            pt_y    <= Y_HOME;
          end
          default: ;
        endcase
      end
      if (state == WRITE) begin
        if (wr_last) begin
          IRAM_valid <= 1'b0;
          done       <= 1'b1;
        end else begin
          IRAM_A <= IRAM_A + AW'(1);
          IRAM_D <= img_buf[IRAM_A + AW'(1)];
        end
      end
    end
  end

  // Buffer contents are plain data and survive reset; they are refilled by every LOAD.
  always_ff @(posedge clk) begin
    if (state == LOAD && vld_p1) begin
      img_buf[addr_p1] <= IROM_Q;
    end else if (accept) begin
      case (cmd_c)
        CMD_MAX: begin
          img_buf[a_tl] <= pix_max; img_buf[a_tr] <= pix_max;
          img_buf[a_bl] <= pix_max; img_buf[a_br] <= pix_max;
        end
        CMD_MIN: begin
          img_buf[a_tl] <= pix_min; img_buf[a_tr] <= pix_min;
          img_buf[a_bl] <= pix_min; img_buf[a_br] <= pix_min;
        end
        CMD_AVG: begin
          img_buf[a_tl] <= pix_avg; img_buf[a_tr] <= pix_avg;
          img_buf[a_bl] <= pix_avg; img_buf[a_br] <= pix_avg;
        end
        CMD_CCW: begin
          img_buf[a_tl] <= w_tr; img_buf[a_tr] <= w_br;
          img_buf[a_br] <= w_bl; img_buf[a_bl] <= w_tl;
        end
        CMD_CW: begin
          img_buf[a_tl] <= w_bl; img_buf[a_bl] <= w_br;
          img_buf[a_br] <= w_tr; img_buf[a_tr] <= w_tl;
        end
        CMD_MIRX: begin
          img_buf[a_tl] <= w_bl; img_buf[a_bl] <= w_tl;
          img_buf[a_tr] <= w_br; img_buf[a_br] <= w_tr;
        end
        CMD_MIRY: begin
          img_buf[a_tl] <= w_tr; img_buf[a_tr] <= w_tl;
          img_buf[a_bl] <= w_br; img_buf[a_br] <= w_bl;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_img_disp_ctrl.sv
// Directed bench for img_disp_ctrl: default 8x8x8 instance plus a 16x4x10 instance for mid-write reset.
module tb_img_disp_ctrl;

  localparam int N = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_a, reset_b;
  logic [3:0] cmd;
  logic       cmd_valid;

  logic [7:0] q_a;  logic [9:0] q_b;
  logic       rd_a, rd_b;
  logic [5:0] ra_a, ra_b;
  logic       v_a, v_b;
  logic [7:0] d_a;  logic [9:0] d_b;
  logic [5:0] wa_a, wa_b;
  logic       busy_a, busy_b, done_a, done_b;

  logic [7:0] rom_a [N];
  logic [9:0] rom_b [N];

  always @(posedge clk) begin
    q_a <= rom_a[ra_a];
    q_b <= rom_b[ra_b];
  end

  img_disp_ctrl u_dut_a (
    .clk(clk), .reset(reset_a), .cmd(cmd), .cmd_valid(cmd_valid),
    .IROM_Q(q_a), .IROM_rd(rd_a), .IROM_A(ra_a),
    .IRAM_valid(v_a), .IRAM_D(d_a), .IRAM_A(wa_a),
    .busy(busy_a), .done(done_a)
  );

  img_disp_ctrl #(.IMG_W_LOG2(4), .IMG_H_LOG2(2), .PIX_W(10)) u_dut_b (
    .clk(clk), .reset(reset_b), .cmd(cmd), .cmd_valid(cmd_valid),
    .IROM_Q(q_b), .IROM_rd(rd_b), .IROM_A(ra_b),
    .IRAM_valid(v_b), .IRAM_D(d_b), .IRAM_A(wa_b),
    .busy(busy_b), .done(done_b)
  );

  // Selected-instance view so the tasks serve both DUTs.
  logic        sel;
  logic        m_busy, m_rd, m_v, m_done;
  logic [5:0]  m_ra, m_wa;
  logic [15:0] m_d;
  assign m_busy = sel ? busy_b : busy_a;
  assign m_rd   = sel ? rd_b   : rd_a;
  assign m_v    = sel ? v_b    : v_a;
  assign m_done = sel ? done_b : done_a;
  assign m_ra   = sel ? ra_b   : ra_a;
  assign m_wa   = sel ? wa_b   : wa_a;
  assign m_d    = sel ? 16'(d_b) : 16'(d_a);

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int         ld_reads, ld_aerr, ld_dones, ld_cyc;
  logic       ld_first_rd;
  logic [5:0] ld_first_a;

  task automatic wait_load();
    ld_reads = 0; ld_aerr = 0; ld_dones = 0; ld_cyc = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (i == 0) begin ld_first_rd = m_rd; ld_first_a = m_ra; end
      if (!m_busy) begin ld_cyc = i; break; end
      if (m_done) ld_dones++;
      if (m_rd) begin
        if (m_ra !== 6'(ld_reads)) ld_aerr++;
        ld_reads++;
      end
    end
    check("load_busy_low", 32'(m_busy), 0);
    check("load_rd_low", 32'(m_rd), 0);
  endtask

  logic [15:0] got  [N];
  logic [15:0] prev [N];
  logic [15:0] expv [N];
  int wr_beats, wr_aerr, wr_done;
  logic wr_busy_at_done, wr_done_after;

  task automatic do_write(input bit hold, input logic [3:0] hold_cmd);
    bit seen;
    seen = 0;
    wr_beats = 0; wr_aerr = 0; wr_done = 0; wr_busy_at_done = 1'b1; wr_done_after = 1'b1;
    @(negedge clk); cmd = 4'h0; cmd_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (hold) cmd = hold_cmd; else cmd_valid = 1'b0;
      if (seen) begin wr_done_after = m_done; break; end
      if (m_v) begin
        if (m_wa !== 6'(wr_beats)) wr_aerr++;
        got[m_wa] = m_d;
        wr_beats++;
        if (m_wa == 6'(N - 1)) cmd_valid = 1'b0;
      end
      if (m_done) begin wr_done++; wr_busy_at_done = m_busy; seen = 1; end
    end
    cmd_valid = 1'b0;
  endtask

  task automatic check_write(input string tag);
    check({tag, "_beats"}, wr_beats, N);
    check({tag, "_addr_err"}, wr_aerr, 0);
    check({tag, "_done_cnt"}, wr_done, 1);
    check({tag, "_busy_at_done"}, 32'(wr_busy_at_done), 0);
    check({tag, "_done_after"}, 32'(wr_done_after), 0);
  endtask

  task automatic issue(input logic [3:0] c);
    @(negedge clk); cmd = c; cmd_valid = 1'b1;
    @(negedge clk); cmd_valid = 1'b0;
  endtask

  task automatic reload_a();
    issue(4'hC);
    wait_load();
    check("reload_reads", ld_reads, N);
    for (int i = 0; i < N; i++) expv[i] = 16'(rom_a[i]);
  endtask

  function automatic int img_diff();
    int e;
    e = 0;
    for (int i = 0; i < N; i++) if (got[i] !== expv[i]) e++;
    return e;
  endfunction

  function automatic int prev_diff();
    int e;
    e = 0;
    for (int i = 0; i < N; i++) if (got[i] !== prev[i]) e++;
    return e;
  endfunction

`ifdef IMG_DISP_CTRL_ROUND_EN
  localparam int AVG_102 = 26;
`else
  localparam int AVG_102 = 25;
`endif

  initial begin
    sel = 1'b0; cmd = 4'h0; cmd_valid = 1'b0;
    reset_a = 1'b0; reset_b = 1'b0;
    for (int i = 0; i < N; i++) begin
      rom_a[i] = 8'(i);
      rom_b[i] = 10'(i);
    end
    repeat (3) @(negedge clk);

    check("rst_busy", 32'(m_busy), 1);
    check("rst_irom_rd", 32'(m_rd), 0);
    check("rst_irom_a", 32'(m_ra), 0);
    check("rst_iram_valid", 32'(m_v), 0);
    check("rst_iram_a", 32'(m_wa), 0);
    check("rst_iram_d", 32'(m_d), 0);
    check("rst_done", 32'(m_done), 0);

    reset_a = 1'b1;
    wait_load();
    check("load_first_rd", 32'(ld_first_rd), 1);
    check("load_first_a", 32'(ld_first_a), 0);
    check("load_reads", ld_reads, N);
    check("load_addr_err", ld_aerr, 0);
    check("load_latency", ld_cyc, 65);
    check("load_no_done", ld_dones, 0);

    for (int i = 0; i < N; i++) expv[i] = 16'(i);
    do_write(0, 4'h0);
    check_write("wr1");
    check("wr1_img", img_diff(), 0);

    // Up x5, Left x5 from (4,4) saturates at (1,1); Max over 0,1,8,9 gives 9
    repeat (5) issue(4'h1);
    repeat (5) issue(4'h3);
    issue(4'h5);
    expv[0] = 16'd9; expv[1] = 16'd9; expv[8] = 16'd9; expv[9] = 16'd9;
    do_write(0, 4'h0);
    check("max_tl", 32'(got[0]), 9);
    check("max_img", img_diff(), 0);

    // Right held through EXEC must move only once: (1,1) -> (2,1)
    @(negedge clk); cmd = 4'h4; cmd_valid = 1'b1;
    @(negedge clk); check("exec_busy", 32'(m_busy), 1);
    @(negedge clk); check("exec_back_idle", 32'(m_busy), 0); cmd_valid = 1'b0;
    issue(4'h2);
    issue(4'h6);
    expv[9] = 16'd9; expv[10] = 16'd9; expv[17] = 16'd9; expv[18] = 16'd9;
    do_write(1, 4'hC);
    check_write("wr_hold");
    check("min_br", 32'(got[18]), 9);
    check("min_img", img_diff(), 0);
    for (int i = 0; i < N; i++) prev[i] = got[i];
    do_write(0, 4'h0);
    check_write("wr_again");
    check("wr_again_same", prev_diff(), 0);

    // Average: 10+20+30+41=101 -> 25 either way
    rom_a[27] = 8'd10; rom_a[28] = 8'd20; rom_a[35] = 8'd30; rom_a[36] = 8'd41;
    reload_a();
    issue(4'h7);
    expv[27] = 16'd25; expv[28] = 16'd25; expv[35] = 16'd25; expv[36] = 16'd25;
    do_write(0, 4'h0);
    check("avg101", 32'(got[27]), 25);
    check("avg101_img", img_diff(), 0);

    // Average: sum 102 -> 25 truncated, 26 rounded
    rom_a[28] = 8'd21;
    reload_a();
    issue(4'h7);
    for (int i = 27; i <= 36; i++) if (i == 27 || i == 28 || i == 35 || i == 36) expv[i] = 16'(AVG_102);
    do_write(0, 4'h0);
    check("avg102", 32'(got[36]), AVG_102);
    check("avg102_img", img_diff(), 0);

    // Rotations and mirrors on TL=1 TR=2 BL=3 BR=4
    rom_a[27] = 8'd1; rom_a[28] = 8'd2; rom_a[35] = 8'd3; rom_a[36] = 8'd4;
    reload_a();
    issue(4'h9);
    expv[27] = 16'd3; expv[28] = 16'd1; expv[35] = 16'd4; expv[36] = 16'd2;
    do_write(0, 4'h0);
    check("cw_tl", 32'(got[27]), 3);
    check("cw_img", img_diff(), 0);
    issue(4'h8);
    expv[27] = 16'd1; expv[28] = 16'd2; expv[35] = 16'd3; expv[36] = 16'd4;
    do_write(0, 4'h0);
    check("ccw_img", img_diff(), 0);
    issue(4'hA);
    expv[27] = 16'd3; expv[28] = 16'd4; expv[35] = 16'd1; expv[36] = 16'd2;
    do_write(0, 4'h0);
    check("mirx_bl", 32'(got[35]), 1);
    check("mirx_img", img_diff(), 0);
    issue(4'hB);
    expv[27] = 16'd4; expv[28] = 16'd3; expv[35] = 16'd2; expv[36] = 16'd1;
    do_write(0, 4'h0);
    check("miry_img", img_diff(), 0);

    // Down x5, Right x5 saturate at (7,7); NOP leaves everything alone
    repeat (5) issue(4'h2);
    repeat (5) issue(4'h4);
    issue(4'hD);
    issue(4'h5);
    expv[54] = 16'd63; expv[55] = 16'd63; expv[62] = 16'd63; expv[63] = 16'd63;
    do_write(0, 4'h0);
    check("sat_max", 32'(got[54]), 63);
    check("sat_img", img_diff(), 0);

    // Second instance: 16x4, 10-bit pixels, reset during write beat 20
    sel = 1'b1;
    @(negedge clk); reset_b = 1'b1;
    wait_load();
    check("b_load_reads", ld_reads, N);
    issue(4'h4);
    @(negedge clk); cmd = 4'h0; cmd_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (m_v && m_wa == 6'd20) break;
    end
    check("b_beat20", 32'(m_wa), 20);
    reset_b = 1'b0;
    #1;
    check("b_rst_valid", 32'(m_v), 0);
    check("b_rst_iram_a", 32'(m_wa), 0);
    check("b_rst_iram_d", 32'(m_d), 0);
    check("b_rst_busy", 32'(m_busy), 1);
    check("b_rst_rd", 32'(m_rd), 0);
    check("b_rst_done", 32'(m_done), 0);
    @(negedge clk); reset_b = 1'b1;
    wait_load();
    check("b_reload_reads", ld_reads, N);
    check("b_reload_first_rd", 32'(ld_first_rd), 1);
    issue(4'h5);
    for (int i = 0; i < N; i++) expv[i] = 16'(i);
    expv[23] = 16'd40; expv[24] = 16'd40; expv[39] = 16'd40; expv[40] = 16'd40;
    do_write(0, 4'h0);
    check_write("b_wr");
    check("b_point_tl", 32'(got[23]), 40);
    check("b_img", img_diff(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1, "watchdog expired");
  end

endmodule
